// File: rtl/hdlc_chk_pkg.sv
// Shared IDs, constants and helpers for the HDLC Rx run-time protocol checker.
package hdlc_chk_pkg;

    typedef enum logic [1:0] {
        CHK_FLAG  = 2'd0,
        CHK_ABORT = 2'd1,
        CHK_IDLE  = 2'd2
    } chk_id_e;

    localparam int NUM_CHK = 3;
    localparam logic [7:0] FLAG_PATTERN = 8'h7E;

    // Fixed priority when several checks fire in the same cycle.
    function automatic chk_id_e first_chk(input logic [NUM_CHK-1:0] viol);
        if (viol[0])
            return CHK_FLAG;
        else if (viol[1])
            return CHK_ABORT;
        else
            return CHK_IDLE;
    endfunction

    function automatic logic [1:0] popcount3(input logic [NUM_CHK-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/hdlc_chk_satcnt.sv
// Saturating event counter: adds 0..3 per cycle, sticks at all-ones, clear wins.
module hdlc_chk_satcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    logic [W+1:0] sum;

    assign sum = {2'b00, cnt} + {{W{1'b0}}, inc};

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (sum > {2'b00, {W{1'b1}}})
            cnt <= '1;
        else
            cnt <= sum[W-1:0];
    end

endmodule

// File: rtl/hdlc_rx_checker.sv
// HDLC Rx protocol checker: flag-detect latency, abort signalling, idle level.
// HDLC_CHK_TIMESTAMP_EN adds a free-running cycle counter and FirstErrTime.
module hdlc_rx_checker
    import hdlc_chk_pkg::*;
#(
`ifdef HDLC_CHK_TIMESTAMP_EN
    parameter int TS_W     = 16,
`endif
    parameter int FLAG_LAT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             Clr,
    input  logic             Rx,
    input  logic             RxEN,
    input  logic             Rx_FlagDetect,
    input  logic             Rx_ValidFrame,
    input  logic             Rx_AbortDetect,
    input  logic             Rx_AbortSignal,
    output logic [2:0]       ErrPulse,
    output logic [2:0]       ErrFlags,
    output logic [CNT_W-1:0] ErrCntFlag,
    output logic [CNT_W-1:0] ErrCntAbort,
    output logic [CNT_W-1:0] ErrCntIdle,
    output logic [CNT_W-1:0] ErrCntTotal,
`ifdef HDLC_CHK_TIMESTAMP_EN
    output logic [TS_W-1:0]  FirstErrTime,
`endif
    output logic             FirstErrValid,
    output logic [1:0]       FirstErrId
);

    logic [6:0]          hist_q;
    logic [7:0]          hist;
    logic [3:0]          fill;
    logic [FLAG_LAT-1:0] flag_dl;
    logic                abort_pend;
    logic                rxen_low_q;
    logic                flag_match;
    logic [NUM_CHK-1:0]  viol;

    // The current Rx sample completes the 8-bit history window.
    assign hist       = {hist_q, Rx};
    assign flag_match = Enable && (fill >= 4'd7) && (hist == FLAG_PATTERN);

    assign viol[0] = Enable && flag_dl[FLAG_LAT-1] && !Rx_FlagDetect;
    assign viol[1] = Enable && abort_pend && !Rx_AbortSignal;
    assign viol[2] = Enable && !RxEN && rxen_low_q && !Rx;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            hist_q     <= '0;
            fill       <= '0;
            flag_dl    <= '0;
            abort_pend <= 1'b0;
            rxen_low_q <= 1'b0;
        end else begin
            rxen_low_q <= !RxEN;
            if (Enable) begin
                hist_q <= hist[6:0];
                if (fill != 4'd8)
                    fill <= fill + 4'd1;
                flag_dl[0] <= flag_match;
                for (int i = 1; i < FLAG_LAT; i++)
                    flag_dl[i] <= flag_dl[i-1];
                abort_pend <= Rx_AbortDetect && Rx_ValidFrame;
            end else begin
                fill       <= '0;
                flag_dl    <= '0;
                abort_pend <= 1'b0;
            end
        end
    end

`ifdef HDLC_CHK_TIMESTAMP_EN
    logic [TS_W-1:0] cyc;

    always_ff @(posedge Clk) begin
        if (!Rst)
            cyc <= '0;
        else
            cyc <= cyc + 1'b1;
    end
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ErrPulse      <= '0;
            ErrFlags      <= '0;
            FirstErrValid <= 1'b0;
            FirstErrId    <= '0;
`ifdef HDLC_CHK_TIMESTAMP_EN
            FirstErrTime  <= '0;
`endif
        end else begin
            ErrPulse <= viol;
            if (Clr) begin
                ErrFlags      <= '0;
                FirstErrValid <= 1'b0;
                FirstErrId    <= '0;
`ifdef HDLC_CHK_TIMESTAMP_EN
                FirstErrTime  <= '0;
`endif
            end else begin
                ErrFlags <= ErrFlags | viol;
                if (!FirstErrValid && (|viol)) begin
                    FirstErrValid <= 1'b1;
                    FirstErrId    <= first_chk(viol);
`ifdef HDLC_CHK_TIMESTAMP_EN
                    FirstErrTime  <= cyc;
`endif
                end
            end
        end
    end

    hdlc_chk_satcnt #(.W(CNT_W)) u_cnt_flag (
        .clk(Clk), .rst(Rst), .clr(Clr), .inc({1'b0, viol[0]}), .cnt(ErrCntFlag)
    );
    hdlc_chk_satcnt #(.W(CNT_W)) u_cnt_abort (
        .clk(Clk), .rst(Rst), .clr(Clr), .inc({1'b0, viol[1]}), .cnt(ErrCntAbort)
    );
    hdlc_chk_satcnt #(.W(CNT_W)) u_cnt_idle (
        .clk(Clk), .rst(Rst), .clr(Clr), .inc({1'b0, viol[2]}), .cnt(ErrCntIdle)
    );
    hdlc_chk_satcnt #(.W(CNT_W)) u_cnt_total (
        .clk(Clk), .rst(Rst), .clr(Clr), .inc(popcount3(viol)), .cnt(ErrCntTotal)
    );

endmodule

// File: tb/tb_hdlc_rx_checker.sv
// Directed, table-driven bench for hdlc_rx_checker (default FLAG_LAT=2, plus a CNT_W=2 copy).
module tb_hdlc_rx_checker;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic Enable = 1'b1;
    logic Clr = 1'b0;
    logic Rx = 1'b1;
    logic RxEN = 1'b1;
    logic Rx_FlagDetect = 1'b0;
    logic Rx_ValidFrame = 1'b0;
    logic Rx_AbortDetect = 1'b0;
    logic Rx_AbortSignal = 1'b0;

    logic [2:0] ErrPulse, ErrFlags;
    logic [7:0] ErrCntFlag, ErrCntAbort, ErrCntIdle, ErrCntTotal;
    logic       FirstErrValid;
    logic [1:0] FirstErrId;

    logic [2:0] b_pulse, b_flags;
    logic [1:0] b_cf, b_ca, b_ci, b_ct;
    logic       b_valid;
    logic [1:0] b_id;
`ifdef HDLC_CHK_TIMESTAMP_EN
    logic [15:0] t_a, t_b;
`endif

    int n_checks = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    hdlc_rx_checker dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Clr(Clr), .Rx(Rx), .RxEN(RxEN),
        .Rx_FlagDetect(Rx_FlagDetect), .Rx_ValidFrame(Rx_ValidFrame),
        .Rx_AbortDetect(Rx_AbortDetect), .Rx_AbortSignal(Rx_AbortSignal),
        .ErrPulse(ErrPulse), .ErrFlags(ErrFlags),
        .ErrCntFlag(ErrCntFlag), .ErrCntAbort(ErrCntAbort),
        .ErrCntIdle(ErrCntIdle), .ErrCntTotal(ErrCntTotal),
`ifdef HDLC_CHK_TIMESTAMP_EN
        .FirstErrTime(t_a),
`endif
        .FirstErrValid(FirstErrValid), .FirstErrId(FirstErrId)
    );

    hdlc_rx_checker #(.CNT_W(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Clr(Clr), .Rx(Rx), .RxEN(RxEN),
        .Rx_FlagDetect(Rx_FlagDetect), .Rx_ValidFrame(Rx_ValidFrame),
        .Rx_AbortDetect(Rx_AbortDetect), .Rx_AbortSignal(Rx_AbortSignal),
        .ErrPulse(b_pulse), .ErrFlags(b_flags),
        .ErrCntFlag(b_cf), .ErrCntAbort(b_ca),
        .ErrCntIdle(b_ci), .ErrCntTotal(b_ct),
`ifdef HDLC_CHK_TIMESTAMP_EN
        .FirstErrTime(t_b),
`endif
        .FirstErrValid(b_valid), .FirstErrId(b_id)
    );

    typedef struct {
        logic       rxen;
        logic       rx;
        logic       ad;
        logic       vf;
        logic       as_;
        logic [2:0] pulse;
    } vec_t;

    vec_t tbl[17];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_pulse"}, {29'd0, ErrPulse}, 0);
        chk({nm, "_flags"}, {29'd0, ErrFlags}, 0);
        chk({nm, "_cnt"}, {ErrCntFlag, ErrCntAbort, ErrCntIdle, ErrCntTotal}, 0);
        chk({nm, "_first"}, {29'd0, FirstErrValid, FirstErrId}, 0);
    endtask

    // Leaves the bench in cycle s+1 (s = cycle of the closing 0), Rx back at 1.
    task automatic send_flag();
        logic [7:0] bits;
        bits = 8'h7E;
        for (int i = 0; i < 8; i++) begin
            Rx = 1'b1;
            step();
        end
        for (int i = 7; i >= 0; i--) begin
            Rx = bits[i];
            step();
        end
        Rx = 1'b1;
    endtask

    task automatic do_clr();
        Clr = 1'b1;
        step();
        Clr = 1'b0;
    endtask

    initial begin
        int ea, ei, et;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100};
        for (int i = 10; i < 16; i++)
            tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};

        // Reset state
        step();
        step();
        chk_all_zero("reset");
        Rst = 1'b1;

        // Flag answered on time
        send_flag();
        step();
        Rx_FlagDetect = 1'b1;
        step();
        Rx_FlagDetect = 1'b0;
        chk("flag_ok_pulse", {29'd0, ErrPulse}, 0);
        step();
        chk("flag_ok_pulse2", {29'd0, ErrPulse}, 0);
        chk("flag_ok_cnt", {24'd0, ErrCntFlag}, 0);

        // Flag never answered: pulse exactly 3 cycles after closing 0
        send_flag();
        step();
        chk("flag_bad_early", {29'd0, ErrPulse}, 0);
        step();
        chk("flag_bad_pulse", {29'd0, ErrPulse}, 3'b001);
        step();
        chk("flag_bad_one_cycle", {29'd0, ErrPulse}, 0);
        chk("flag_bad_cnt", {24'd0, ErrCntFlag}, 1);
        chk("flag_bad_total", {24'd0, ErrCntTotal}, 1);
        chk("flag_bad_first", {29'd0, FirstErrValid, FirstErrId}, 3'b100);
        chk("flag_bad_flags", {29'd0, ErrFlags}, 3'b001);

        do_clr();
        chk_all_zero("clr");

        // Abort and idle table
        ea = 0; ei = 0; et = 0;
        for (int i = 0; i < 17; i++) begin
            RxEN = tbl[i].rxen;
            Rx = tbl[i].rx;
            Rx_AbortDetect = tbl[i].ad;
            Rx_ValidFrame = tbl[i].vf;
            Rx_AbortSignal = tbl[i].as_;
            step();
            chk($sformatf("tbl_pulse_%0d", i), {29'd0, ErrPulse}, {29'd0, tbl[i].pulse});
            ea += int'(tbl[i].pulse[1]);
            ei += int'(tbl[i].pulse[2]);
            et += int'(tbl[i].pulse[1]) + int'(tbl[i].pulse[2]);
        end
        chk("tbl_cnt_abort", {24'd0, ErrCntAbort}, ea);
        chk("tbl_cnt_idle", {24'd0, ErrCntIdle}, ei);
        chk("tbl_cnt_total", {24'd0, ErrCntTotal}, et);
        chk("tbl_first", {29'd0, FirstErrValid, FirstErrId}, 3'b101);
        chk("tbl_flags", {29'd0, ErrFlags}, 3'b110);

        // FLAG and IDLE in the same cycle
        do_clr();
        send_flag();
        RxEN = 1'b0;
        step();
        Rx = 1'b0;
        step();
        RxEN = 1'b1;
        Rx = 1'b1;
        chk("simul_pulse", {29'd0, ErrPulse}, 3'b101);
        chk("simul_total", {24'd0, ErrCntTotal}, 2);
        chk("simul_first", {29'd0, FirstErrValid, FirstErrId}, 3'b100);
        chk("simul_cnt_idle", {24'd0, ErrCntIdle}, 1);

        // Saturation with CNT_W=2
        do_clr();
        for (int k = 0; k < 5; k++) begin
            Rx_AbortDetect = 1'b1;
            Rx_ValidFrame = 1'b1;
            step();
            Rx_AbortDetect = 1'b0;
            Rx_ValidFrame = 1'b0;
            step();
        end
        chk("sat_cnt_abort_w8", {24'd0, ErrCntAbort}, 5);
        chk("sat_cnt_abort_w2", {30'd0, b_ca}, 3);
        chk("sat_cnt_total_w2", {30'd0, b_ct}, 3);

        // Clr in the same cycle as a violation
        Rx_AbortDetect = 1'b1;
        Rx_ValidFrame = 1'b1;
        step();
        Rx_AbortDetect = 1'b0;
        Rx_ValidFrame = 1'b0;
        Clr = 1'b1;
        step();
        Clr = 1'b0;
        chk("clr_beats_inc_abort", {24'd0, ErrCntAbort}, 0);
        chk("clr_beats_inc_total", {24'd0, ErrCntTotal}, 0);
        chk("clr_beats_inc_first", {29'd0, FirstErrValid, ErrFlags}, 0);
        step();
        chk("clr_after_abort", {24'd0, ErrCntAbort}, 0);

        // Enable low flushes a pending flag check and holds counters
        Rx_AbortDetect = 1'b1;
        Rx_ValidFrame = 1'b1;
        step();
        Rx_AbortDetect = 1'b0;
        Rx_ValidFrame = 1'b0;
        step();
        send_flag();
        Enable = 1'b0;
        step();
        step();
        Enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("en_flush_pulse", {29'd0, ErrPulse}, 0);
        end
        chk("en_hold_abort", {24'd0, ErrCntAbort}, 1);
        chk("en_flush_flag", {24'd0, ErrCntFlag}, 0);

        // Reset during a pending flag check
        send_flag();
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        chk_all_zero("rst_pending");
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_no_stale_pulse", {29'd0, ErrPulse}, 0);
        end
        chk("rst_cnt_flag", {24'd0, ErrCntFlag}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_checker.md
# hdlc_rx_checker

Synthesizable run-time protocol checker for the HDLC Rx path. It replaces simulation-only concurrent assertions with registered hardware checks, so the same checks run in emulation and on FPGA. It samples the serial Rx line and the Rx status strobes, and checks three rules: flag-detect latency, abort signalling and idle line level. It keeps per-check saturating error counters, sticky flags and first-error capture, and sits beside the Rx block, reading its signals without driving any of them.

## Interface
- FLAG_LAT, 2: cycles from the sample holding the last flag bit to the cycle where Rx_FlagDetect must be 1; legal range 1..8.
- CNT_W, 8: width of every error counter.
- TS_W, 16: width of the free-running cycle counter and of FirstErrTime.
- Clk  in  1  system clock; all logic on its rising edge.
- Rst  in  1  synchronous, active-low reset.
- Enable  in  1  checks evaluated only while 1.
- Clr  in  1  single-cycle clear of counters, flags and first-error capture.
- Rx  in  1  serial receive line, one bit per cycle.
- RxEN  in  1  receiver enable.
- Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal  in  1 each  Rx status strobes.
- ErrPulse  out  3  one-cycle error strobe per check: [0] FLAG, [1] ABORT, [2] IDLE.
- ErrFlags  out  3  sticky copy of ErrPulse.
- ErrCntFlag, ErrCntAbort, ErrCntIdle  out  CNT_W each  per-check saturating counts.
- ErrCntTotal  out  CNT_W  saturating sum of all error events.
- FirstErrValid  out  1  set by the first error after reset or Clr.
- FirstErrId  out  2  check ID of the first error.
- FirstErrTime  out  TS_W  cycle stamp of the first error; only with macro.

## Operation
- History shift register: 8-bit, newest sample in bit 0. A fill counter (0..8) marks the history valid once 8 samples are taken after reset or after Enable rises.
- FLAG check: the history equals 0,1,1,1,1,1,1,0 in time order (8'h7E) and the history is valid. The match enters a FLAG_LAT-deep delay line. When a match leaves the delay line and Rx_FlagDetect is 0, the check is violated. Overlapping flags (shared 0) each start their own check.
- ABORT check: if Rx_AbortDetect and Rx_ValidFrame are both 1 in cycle n, Rx_AbortSignal must be 1 in cycle n+1. The check is violated otherwise.
- IDLE check: in a cycle where RxEN has been 0 for at least 2 consecutive cycles, Rx must be 1. Every offending cycle is one violation.
- Enable=0: no checks are evaluated, and the delay line, the fill counter and the pending ABORT state are flushed. Counters and flags hold their values.
- Counters: each counter stops at all-ones. ErrCntTotal adds the popcount of the violations in a cycle (0..3), clamped at all-ones.
- First-error capture:
  - It records only when FirstErrValid is 0.
  - For simultaneous errors, priority is FLAG over ABORT over IDLE.
  - The captured values hold until Clr or reset.
- Clr beats any increment in the same cycle; the counters read 0 the next cycle. Clr does not touch the history, the delay line or the cycle counter.

## Timing
- Violation found in cycle t: ErrPulse, ErrFlags, the counters and the first-error fields all update on the edge ending t, visible in t+1.
- FLAG: with the last flag bit sampled in cycle s, Rx_FlagDetect is sampled in cycle s+FLAG_LAT and ErrPulse[0] rises in s+FLAG_LAT+1.
- Reset (Rst=0 at an edge): every output is 0, and the history, fill counter, delay line and cycle counter are cleared. Reset in the middle of a pending FLAG check drops that check without an error.
- Cycle counter: counts every cycle after reset and wraps from all-ones to 0.

## Configuration
- HDLC_CHK_TIMESTAMP_EN defined: the TS_W cycle counter and the FirstErrTime port exist. FirstErrTime holds the counter value of cycle t of the first error.
- Not defined: there is no cycle counter and no FirstErrTime port. All other behaviour is identical.

## Structure
- Package hdlc_chk_pkg holds:
  - the chk_id_e enum: CHK_FLAG=0, CHK_ABORT=1, CHK_IDLE=2;
  - NUM_CHK=3;
  - FLAG_PATTERN=8'h7E.
- Sub-module hdlc_chk_satcnt is a saturating counter with clear and an increment input (0..3). It is instantiated four times: three per-check counters and the total.

## Test plan
- 01111110 with Rx_FlagDetect=1 two cycles after the last 0 (FLAG_LAT=2): ErrPulse stays 0 and ErrCntFlag=0.
- Same flag with Rx_FlagDetect held 0: ErrPulse[0] is high exactly 3 cycles after the last 0. ErrCntFlag=1, FirstErrId=0, FirstErrValid=1.
- Rx_AbortDetect=Rx_ValidFrame=1 for one cycle, then Rx_AbortSignal=0: ErrCntAbort=1. With Rx_AbortSignal=1 instead there is no error.
- RxEN=0 for 10 cycles with Rx=0 in cycles 3 and 4: ErrCntIdle=2 and ErrCntTotal=2.
- FLAG and IDLE violated in the same cycle: ErrCntTotal rises by 2 and FirstErrId=0. With CNT_W=2 and 5 ABORT errors, ErrCntAbort=3.
- Clr together with a violation, then reset during a pending flag check: the counters read 0 after Clr. After reset all outputs are 0 and no stale ErrPulse appears.
